// File: rtl/lmsm_reg_sequencer.sv
// lmsm_reg_sequencer
//   Sequential priority scanner for LM/SM multi-register transfers. A load
//   captures a register-select mask and a scan direction. Each transfer step
//   then presents the index of one selected register. An advance consumes
//   that index and clears its bit, until the mask is exhausted.
//
// Parameters
//   WIDTH  number of registers / mask width (>= 2)
//   IDX_W  index width, $clog2(WIDTH)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   load   in   capture mask/dir and (re)start a sequence; overrides adv
//   mask   in   register-select bits, bit i selects register i
//   dir    in   0 = highest set bit first, 1 = lowest set bit first
//   adv    in   consume current index (ignored outside SCAN)
//   idx    out  current register index (0 when nothing is pending)
//   valid  out  idx is meaningful (SCAN)
//   last   out  current index is the final one of the sequence
//   busy   out  sequence in progress (SCAN)
//   done   out  one-cycle pulse at sequence end
//   count  out  indices not yet consumed, including the current one
//
// Optional feature macro: LMSM_COUNT_EN
//   defined   -> count driven by a registered remaining-index counter
//   undefined -> count tied to zero, no counter logic
//
// All outputs decode from registered state only. There is no
// combinational path from any input to any output.

module lmsm_reg_sequencer #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] mask,
  input  logic             dir,
  input  logic             adv,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic [IDX_W:0]   count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic             dir_q;

  // Combinational decode of the registered scan state
  logic [IDX_W-1:0] enc_idx;
  logic [WIDTH-1:0] clr_bit;
  logic             pend_onehot;

  // Priority encoder. The loop order makes the last matching bit win:
  // an ascending loop leaves the highest set bit, a descending loop the lowest.
  always_comb begin
    enc_idx = '0;
    if (!dir_q) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (pending[i]) enc_idx = IDX_W'(i);
      end
    end else begin
      for (int unsigned i = WIDTH; i > 0; i--) begin
        if (pending[i-1]) enc_idx = IDX_W'(i-1);
      end
    end
  end

  // One-hot mask of the bit consumed by an advance
  always_comb begin
    clr_bit = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      clr_bit[i] = (IDX_W'(i) == enc_idx) && pending[i];
    end
  end

  // Exactly one bit pending: nonzero and clearing the lowest set bit leaves zero
  always_comb begin
    pend_onehot = (pending != '0) && ((pending & (pending - 1'b1)) == '0);
  end

`ifdef LMSM_COUNT_EN
  logic [IDX_W:0] cnt_q;

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] n;
    n = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      n = n + {{IDX_W{1'b0}}, v[i]};
    end
    return n;
  endfunction
`endif

  // Single sequential process: FSM, pending mask, direction, optional counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      dir_q   <= 1'b0;
`ifdef LMSM_COUNT_EN
      cnt_q   <= '0;
`endif
    end else if (load) begin
      // load restarts from any state; a same-cycle adv is dropped
      dir_q   <= dir;
      pending <= mask;
`ifdef LMSM_COUNT_EN
      cnt_q   <= popcount(mask);
`endif
      if (mask != '0) state <= SCAN;
      else            state <= DONE;
    end else begin
      unique case (state)
        IDLE: begin
          state <= IDLE;
        end
        SCAN: begin
          if (adv) begin
            pending <= pending & ~clr_bit;
`ifdef LMSM_COUNT_EN
            cnt_q   <= cnt_q - 1'b1;
`endif
            if (pend_onehot) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

  // Output decode from registers only
  always_comb begin
    valid = (state == SCAN);
    busy  = (state == SCAN);
    done  = (state == DONE);
    idx   = enc_idx;
    last  = valid && pend_onehot;
`ifdef LMSM_COUNT_EN
    count = valid ? cnt_q : '0;
`else
    count = '0;
`endif
  end

endmodule

// File: tb/tb_lmsm_reg_sequencer.sv
module tb_lmsm_reg_sequencer;

  logic       clk;
  logic       rst_n;

  // WIDTH=8 instance
  logic       load, dir, adv;
  logic [7:0] mask;
  logic [2:0] idx;
  logic       valid, last, busy, done;
  logic [3:0] count;

  // WIDTH=16 instance
  logic        load16, dir16, adv16;
  logic [15:0] mask16;
  logic [3:0]  idx16;
  logic        valid16, last16, busy16, done16;
  logic [4:0]  count16;

  int errors = 0;
  int checks = 0;

  lmsm_reg_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .mask(mask), .dir(dir), .adv(adv),
    .idx(idx), .valid(valid), .last(last), .busy(busy), .done(done), .count(count)
  );

  lmsm_reg_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .load(load16), .mask(mask16), .dir(dir16), .adv(adv16),
    .idx(idx16), .valid(valid16), .last(last16), .busy(busy16), .done(done16),
    .count(count16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected count value depends on whether the counter feature is built
  function automatic logic [31:0] cexp(input int n);
`ifdef LMSM_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the full WIDTH=8 output set
  task automatic chk8(input string tag, input logic [2:0] e_idx, input logic e_valid,
                      input logic e_last, input logic e_done, input int e_cnt);
    check({tag, ".idx"},   {29'd0, idx},  {29'd0, e_idx});
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, e_valid});
    check({tag, ".busy"},  {31'd0, busy},  {31'd0, e_valid});
    check({tag, ".last"},  {31'd0, last},  {31'd0, e_last});
    check({tag, ".done"},  {31'd0, done},  {31'd0, e_done});
    check({tag, ".count"}, {28'd0, count}, cexp(e_cnt));
  endtask

  initial begin
    rst_n = 1'b0;
    load = 0; dir = 0; adv = 0; mask = '0;
    load16 = 0; dir16 = 0; adv16 = 0; mask16 = '0;

    // Reset state
    #3;
    chk8("reset", 3'd0, 0, 0, 0, 0);
    #9 rst_n = 1'b1;
    step();
    chk8("idle", 3'd0, 0, 0, 0, 0);

    // adv in IDLE is ignored
    adv = 1;
    step();
    chk8("adv_idle", 3'd0, 0, 0, 0, 0);

    // MSB-first, adv held high: 7, 2, 0(last), done
    load = 1; mask = 8'b1000_0101; dir = 0; adv = 0;
    step();
    chk8("msb0", 3'd7, 1, 0, 0, 3);
    load = 0; adv = 1;
    step();
    chk8("msb1", 3'd2, 1, 0, 0, 2);
    step();
    chk8("msb2", 3'd0, 1, 1, 0, 1);
    step();
    chk8("msb_done", 3'd0, 0, 0, 1, 0);
    step();
    chk8("msb_idle", 3'd0, 0, 0, 0, 0);
    adv = 0;

    // LSB-first with stalls: 5 held, then 6 last, then done
    load = 1; mask = 8'b0110_0000; dir = 1;
    step();
    chk8("lsb0", 3'd5, 1, 0, 0, 2);
    load = 0;
    step();
    chk8("lsb_hold1", 3'd5, 1, 0, 0, 2);
    adv = 1;
    step();
    chk8("lsb1", 3'd6, 1, 1, 0, 1);
    adv = 0;
    step();
    chk8("lsb_hold2", 3'd6, 1, 1, 0, 1);
    adv = 1;
    step();
    chk8("lsb_done", 3'd0, 0, 0, 1, 0);
    adv = 0;
    step();
    chk8("lsb_idle", 3'd0, 0, 0, 0, 0);

    // Empty mask: done next cycle, never valid
    load = 1; mask = 8'h00; dir = 0;
    step();
    chk8("empty_done", 3'd0, 0, 0, 1, 0);

    // load during DONE behaves as in IDLE: mask 03, LSB-first -> idx 0
    mask = 8'h03; dir = 1;
    step();
    chk8("done_load", 3'd0, 1, 0, 0, 2);
    load = 0;

    // Restart during SCAN of FF with same-cycle adv (adv dropped)
    load = 1; mask = 8'hFF; dir = 0;
    step();
    chk8("ff0", 3'd7, 1, 0, 0, 8);
    load = 0; adv = 1;
    step();
    chk8("ff1", 3'd6, 1, 0, 0, 7);
    load = 1; mask = 8'h10;
    step();
    chk8("restart", 3'd4, 1, 1, 0, 1);
    load = 0;
    step();
    chk8("restart_done", 3'd0, 0, 0, 1, 0);
    adv = 0;

    // WIDTH=16 MSB-first: 15, 0(last), done
    load16 = 1; mask16 = 16'h8001; dir16 = 0;
    step();
    check("w16_0.idx", {28'd0, idx16}, 32'd15);
    check("w16_0.valid", {31'd0, valid16}, 32'd1);
    check("w16_0.last", {31'd0, last16}, 32'd0);
    check("w16_0.count", {27'd0, count16}, cexp(2));
    load16 = 0; adv16 = 1;
    step();
    check("w16_1.idx", {28'd0, idx16}, 32'd0);
    check("w16_1.last", {31'd0, last16}, 32'd1);
    check("w16_1.count", {27'd0, count16}, cexp(1));
    step();
    check("w16_done", {31'd0, done16}, 32'd1);
    check("w16_done.valid", {31'd0, valid16}, 32'd0);
    adv16 = 0;

    // Reset mid-SCAN: outputs drop asynchronously
    load = 1; mask = 8'hA5; dir = 0;
    step();
    chk8("a5", 3'd7, 1, 0, 0, 4);
    load = 0;
    #2 rst_n = 1'b0;
    #1;
    chk8("async_rst", 3'd0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    step();
    chk8("post_rst", 3'd0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
